// File: rtl/alu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package : alu_pkg                                                  |
// | Shared opcode encoding and issue-FSM state type for the ALU and    |
// | the alu_issue sequencer.                                           |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_SLTU = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_LAST = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  // Opcodes above OP_LAST are reserved and get rejected at issue.
  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= OP_LAST);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Interface : alu_issue_if                                           |
// | Instruction handshake, ALU operand/result and writeback bundle.    |
// | Optional macro ALU_ISSUE_IMM_EN adds instr_imm_sel / instr_imm.    |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
interface alu_issue_if #(
  parameter int NUM_REGS = 8
) ();

  logic                        instr_valid;
  logic                        instr_ready;
  logic [3:0]                  instr_op;
  logic [$clog2(NUM_REGS)-1:0] instr_rd;
  logic [$clog2(NUM_REGS)-1:0] instr_rs1;
  logic [$clog2(NUM_REGS)-1:0] instr_rs2;
`ifdef ALU_ISSUE_IMM_EN
  logic                        instr_imm_sel;
  logic [31:0]                 instr_imm;
`endif
  logic [31:0]                 alu_a;
  logic [31:0]                 alu_b;
  logic [3:0]                  alu_op;
  logic [31:0]                 alu_out;
  logic                        res_valid;
  logic [$clog2(NUM_REGS)-1:0] res_rd;
  logic [31:0]                 res_data;
  logic                        illegal;

  // Instruction source and ALU side
  modport master (
`ifdef ALU_ISSUE_IMM_EN
    output instr_imm_sel, instr_imm,
`endif
    output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, alu_out,
    input  instr_ready, alu_a, alu_b, alu_op, res_valid, res_rd, res_data, illegal
  );

  // Issue sequencer side
  modport slave (
`ifdef ALU_ISSUE_IMM_EN
    input  instr_imm_sel, instr_imm,
`endif
    input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, alu_out,
    output instr_ready, alu_a, alu_b, alu_op, res_valid, res_rd, res_data, illegal
  );

endinterface
`default_nettype wire

// File: rtl/alu_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : alu_regfile                                               |
// | Register file: two async operand reads, async debug read, one      |
// | synchronous write port. Register 0 is hardwired to zero.           |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module alu_regfile #(
  parameter int NUM_REGS = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_we,
  input  logic [$clog2(NUM_REGS)-1:0] i_waddr,
  input  logic [31:0]                 i_wdata,
  input  logic [$clog2(NUM_REGS)-1:0] i_raddr_a,
  output logic [31:0]                 o_rdata_a,
  input  logic [$clog2(NUM_REGS)-1:0] i_raddr_b,
  output logic [31:0]                 o_rdata_b,
  input  logic [$clog2(NUM_REGS)-1:0] i_dbg_addr,
  output logic [31:0]                 o_dbg_data
);

  logic [31:0] r_mem [NUM_REGS];

  // Storage: cleared on reset, writes to register 0 are dropped
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we && (i_waddr != '0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Register 0 is forced to zero on every read port
  assign o_rdata_a  = (i_raddr_a  == '0) ? '0 : r_mem[i_raddr_a];
  assign o_rdata_b  = (i_raddr_b  == '0) ? '0 : r_mem[i_raddr_b];
  assign o_dbg_data = (i_dbg_addr == '0) ? '0 : r_mem[i_dbg_addr];

endmodule
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : alu_issue                                                 |
// | Serial single-issue sequencer for an external ALU: reads operands  |
// | from the register file, waits ALU_LAT cycles, writes back result.  |
// | Optional macro ALU_ISSUE_IMM_EN selects an immediate for alu_b.    |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module alu_issue
  import alu_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int ALU_LAT  = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  alu_issue_if.slave                  bus,
  input  logic [$clog2(NUM_REGS)-1:0] dbg_addr,
  output logic [31:0]                 dbg_data
);

  localparam int                 c_cnt_w    = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(ALU_LAT - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic               w_accept;
  logic               w_legal;
  logic               w_issue;
  logic               w_last;
  logic [31:0]        w_rs1_data;
  logic [31:0]        w_rs2_data;
  logic [31:0]        w_opb;

  // Ready is a pure function of the state, so accept is computed from the
  // state directly to keep it independent of the ready output path.
  assign w_accept = bus.instr_valid && (r_state == S_IDLE);
  assign w_legal  = op_is_legal(bus.instr_op);
  assign w_issue  = w_accept && w_legal;
  assign w_last   = (r_cnt == '0);

`ifdef ALU_ISSUE_IMM_EN
  assign w_opb = bus.instr_imm_sel ? bus.instr_imm : w_rs2_data;
`else
  assign w_opb = w_rs2_data;
`endif

  // res_valid is high exactly during WB, so it doubles as the write enable;
  // a reset during EXEC/WB clears it and no write happens.
  alu_regfile #(
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk        (clk),
    .reset      (reset),
    .i_we       (bus.res_valid),
    .i_waddr    (bus.res_rd),
    .i_wdata    (bus.res_data),
    .i_raddr_a  (bus.instr_rs1),
    .o_rdata_a  (w_rs1_data),
    .i_raddr_b  (bus.instr_rs2),
    .o_rdata_b  (w_rs2_data),
    .i_dbg_addr (dbg_addr),
    .o_dbg_data (dbg_data)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and ready decode
  always_comb begin
    w_state_nxt     = r_state;
    bus.instr_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.instr_ready = 1'b1;
        if (w_issue) begin
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (w_last) begin
          w_state_nxt = S_WB;
        end
      end
      S_WB: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand latch, latency counter, result capture and status pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.alu_a     <= '0;
      bus.alu_b     <= '0;
      bus.alu_op    <= '0;
      bus.res_valid <= 1'b0;
      bus.res_rd    <= '0;
      bus.res_data  <= '0;
      bus.illegal   <= 1'b0;
      r_cnt         <= '0;
    end else begin
      bus.illegal   <= w_accept && !w_legal;
      bus.res_valid <= (r_state == S_EXEC) && w_last;
      if (w_issue) begin
        bus.alu_a  <= w_rs1_data;
        bus.alu_b  <= w_opb;
        bus.alu_op <= bus.instr_op;
        bus.res_rd <= bus.instr_rd;
        r_cnt      <= c_cnt_init;
      end else if ((r_state == S_EXEC) && !w_last) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if ((r_state == S_EXEC) && w_last) begin
        bus.res_data <= bus.alu_out;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : tb_alu_issue                                              |
// | Self-checking bench for alu_issue: directed scenarios followed by  |
// | random instructions against an architectural register model.      |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_alu_issue;
  import alu_pkg::*;

  localparam int NUM_REGS = 8;
  localparam int ALU_LAT  = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [31:0] m_rf [NUM_REGS];
  int          n_vec = 0;
  int          n_mis = 0;

  alu_issue_if #(.NUM_REGS(NUM_REGS)) bus ();

  alu_issue #(
    .NUM_REGS (NUM_REGS),
    .ALU_LAT  (ALU_LAT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  // Architectural meaning of each opcode
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOR:  return ~(a | b);
      OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
      OP_SHL:  return a << b[4:0];
      OP_SHR:  return a >> b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  // External ALU stand-in
  always_comb bus.alu_out = ref_alu(bus.alu_op, bus.alu_a, bus.alu_b);

`ifdef ALU_ISSUE_IMM_EN
  initial begin
    bus.instr_imm_sel = 1'b0;
    bus.instr_imm     = 32'd0;
  end
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Read every register through the debug port, one per cycle
  task automatic sweep();
    for (int i = 0; i < NUM_REGS; i++) begin
      @(negedge clk);
      dbg_addr = 3'(i);
      #1;
      check("rf_sweep", dbg_data, m_rf[i]);
    end
  endtask

  task automatic do_reset();
    bus.instr_valid = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_alu_a",     bus.alu_a, 32'd0);
    check("rst_alu_b",     bus.alu_b, 32'd0);
    check("rst_alu_op",    32'(bus.alu_op), 32'd0);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_res_rd",    32'(bus.res_rd), 32'd0);
    check("rst_res_data",  bus.res_data, 32'd0);
    check("rst_illegal",   32'(bus.illegal), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) m_rf[i] = 32'd0;
    @(negedge clk);
    check("rst_ready", 32'(bus.instr_ready), 32'd1);
  endtask

  // Offer one instruction while the DUT idles; hold keeps instr_valid high
  task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input bit hold);
    logic [31:0] a, b, exp;
    int lat;
    a   = m_rf[rs1];
    b   = m_rf[rs2];
    exp = ref_alu(op, a, b);
    bus.instr_valid = 1'b1;
    bus.instr_op    = op;
    bus.instr_rd    = rd;
    bus.instr_rs1   = rs1;
    bus.instr_rs2   = rs2;
    dbg_addr        = rd;
    #1;
    check("ready_idle", 32'(bus.instr_ready), 32'd1);
    @(posedge clk);
    if (op > OP_LAST) begin
      @(negedge clk);
      bus.instr_valid = 1'b0;
      check("illegal_pulse",  32'(bus.illegal), 32'd1);
      check("illegal_no_res", 32'(bus.res_valid), 32'd0);
      check("illegal_ready",  32'(bus.instr_ready), 32'd1);
      @(negedge clk);
      check("illegal_once",   32'(bus.illegal), 32'd0);
      check("illegal_no_res", 32'(bus.res_valid), 32'd0);
      sweep();
    end else begin
      lat = 0;
      for (int k = 1; k <= ALU_LAT + 3; k++) begin
        @(negedge clk);
        if (k == 1 && !hold) bus.instr_valid = 1'b0;
        check("hold_alu_op", 32'(bus.alu_op), 32'(op));
        check("hold_alu_a",  bus.alu_a, a);
        check("hold_alu_b",  bus.alu_b, b);
        check("ready_busy",  32'(bus.instr_ready), 32'd0);
        if (bus.res_valid) begin
          lat = k;
          break;
        end
      end
      check("latency", 32'(lat), 32'(ALU_LAT + 1));
      if (lat != 0) begin
        check("res_rd",   32'(bus.res_rd), 32'(rd));
        check("res_data", bus.res_data, exp);
        check("dbg_prewrite", dbg_data, m_rf[rd]);
        if (rd != 3'd0) m_rf[rd] = exp;
        @(negedge clk);
        check("res_once",      32'(bus.res_valid), 32'd0);
        check("ready_back",    32'(bus.instr_ready), 32'd1);
        check("dbg_postwrite", dbg_data, m_rf[rd]);
      end
    end
  endtask

  initial begin
    logic [3:0] op;
    reset           = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr_op    = 4'd0;
    bus.instr_rd    = 3'd0;
    bus.instr_rs1   = 3'd0;
    bus.instr_rs2   = 3'd0;
    dbg_addr        = 3'd0;

    do_reset();
    sweep();

    // Build r1=5, r2=3 from the zeroed file
    issue(OP_NOR, 3'd1, 3'd0, 3'd0, 1'b0);  // r1 = ffffffff
    issue(OP_SUB, 3'd2, 3'd0, 3'd1, 1'b0);  // r2 = 1
    issue(OP_ADD, 3'd3, 3'd2, 3'd2, 1'b0);  // r3 = 2
    issue(OP_ADD, 3'd4, 3'd3, 3'd2, 1'b0);  // r4 = 3
    issue(OP_ADD, 3'd5, 3'd4, 3'd3, 1'b0);  // r5 = 5
    issue(OP_ADD, 3'd1, 3'd5, 3'd0, 1'b0);  // r1 = 5
    issue(OP_ADD, 3'd2, 3'd4, 3'd0, 1'b0);  // r2 = 3
    issue(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0);  // r3 = 8
    issue(OP_SUB, 3'd0, 3'd1, 3'd2, 1'b0);  // result 2, r0 untouched
    issue(4'hC,   3'd3, 3'd1, 3'd2, 1'b0);  // rejected
    issue(OP_ADD, 3'd1, 3'd1, 3'd1, 1'b1);  // 10, valid held
    issue(OP_ADD, 3'd1, 3'd1, 3'd1, 1'b0);  // 20

    // Reset while the instruction sits in EXEC
    bus.instr_valid = 1'b1;
    bus.instr_op    = OP_ADD;
    bus.instr_rd    = 3'd3;
    bus.instr_rs1   = 3'd1;
    bus.instr_rs2   = 3'd2;
    @(posedge clk);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    check("exec_busy", 32'(bus.instr_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("abort_res_valid", 32'(bus.res_valid), 32'd0);
    check("abort_alu_a",     bus.alu_a, 32'd0);
    check("abort_alu_op",    32'(bus.alu_op), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) m_rf[i] = 32'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_res", 32'(bus.res_valid), 32'd0);
      check("abort_ready",  32'(bus.instr_ready), 32'd1);
    end
    sweep();

    // Random traffic against the register model
    issue(OP_NOR, 3'd7, 3'd0, 3'd0, 1'b0);
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 7) == 0) op = 4'($urandom_range(10, 15));
      else                           op = 4'($urandom_range(0, 9));
      issue(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end
    bus.instr_valid = 1'b0;
    sweep();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8, register-file depth, power of two, minimum 2.
REQ-002 SHALL have parameter ALU_LAT, default 1, ALU result latency in cycles, minimum 1.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port instr_valid  input  1  instruction offered.
REQ-006 SHALL have port instr_ready  output  1  instruction accepted when valid and ready are both high.
REQ-007 SHALL have port instr_op  input  4  ALU opcode (ADD=0 … SHR=9).
REQ-008 SHALL have ports instr_rd, instr_rs1, instr_rs2  input  log2(NUM_REGS) each  destination and source register indices.
REQ-009 SHALL have ports alu_a, alu_b  output  32  registered ALU operands.
REQ-010 SHALL have port alu_op  output  4  registered ALU opcode.
REQ-011 SHALL have port alu_out  input  32  ALU result.
REQ-012 SHALL have ports res_valid (output 1), res_rd (output log2(NUM_REGS)), res_data (output 32)  writeback notification.
REQ-013 SHALL have port illegal  output  1  one-cycle pulse for rejected opcode.
REQ-014 SHALL have ports dbg_addr (input log2(NUM_REGS)) and dbg_data (output 32)  combinational register-file read.

Function
REQ-015 SHALL implement FSM IDLE -> EXEC -> WB -> IDLE; instr_ready SHALL be high only in IDLE.
REQ-016 On handshake in IDLE with opcode 0–9, SHALL latch alu_a=rf[rs1], alu_b=rf[rs2], alu_op=op, rd, and enter EXEC.
REQ-017 SHALL remain in EXEC exactly ALU_LAT cycles (down-counter), sample alu_out on the last EXEC edge, then enter WB.
REQ-018 In WB, SHALL assert res_valid for exactly one cycle with res_rd/res_data, write rf[rd] on that edge, and return to IDLE.
REQ-019 Accept-to-res_valid latency SHALL be ALU_LAT+1 cycles; throughput one instruction per ALU_LAT+2 cycles.
REQ-020 Register 0 SHALL read as zero; writes to register 0 SHALL be discarded while res_valid still pulses.
REQ-021 On handshake with opcode 10–15, SHALL pulse illegal for one cycle, leave rf unchanged, no res_valid, and stay in IDLE.
REQ-022 rd equal to rs1/rs2 SHALL read old values; next instruction SHALL see the written value (no hazard, serial issue).
REQ-023 dbg_data during WB SHALL return the pre-write value; post-write value from the following cycle.
REQ-024 alu_a/alu_b/alu_op SHALL hold stable from EXEC entry through WB.

Reset
REQ-025 Reset assertion SHALL immediately force IDLE, rf all zero, alu_a=alu_b=0, alu_op=0, res_valid=0, res_rd=0, res_data=0, illegal=0, counter=0.
REQ-026 Reset during EXEC or WB SHALL abort the instruction with no register write.
REQ-027 instr_ready SHALL read 1 from the first edge after reset deassertion.

Configuration
REQ-028 Macro ALU_ISSUE_IMM_EN SHALL, when defined, add inputs instr_imm_sel (1) and instr_imm (32); alu_b SHALL take instr_imm when instr_imm_sel=1 at accept.
REQ-029 Without ALU_ISSUE_IMM_EN those ports SHALL be absent and alu_b SHALL always be rf[rs2].

Structure
REQ-030 Opcode constants (OP_ADD…OP_SHR), OP_LAST=9, and the FSM state enum SHALL live in shared package alu_pkg, shared with the ALU.
REQ-031 The register file SHALL be sub-module alu_regfile (one async read port per operand plus debug, one sync write port, r0 zero, async active-low clear).

Verification
REQ-032 Reset, then dbg_addr sweep 0..7 -> all dbg_data=0, instr_ready=1.
REQ-033 Preload r1=5, r2=3 (ADD from r0 with imm, or backdoor); ADD rd=3 -> res_valid at accept+2, res_data=8, r3=8.
REQ-034 SUB rd=0 rs1=1 rs2=2 -> res_valid with res_rd=0, res_data=2; dbg r0 stays 0.
REQ-035 instr_op=4'hC offered -> illegal pulses once, no res_valid, all registers unchanged, instr_ready stays 1.
REQ-036 ADD r1=r1+r1 with r1=5, back-to-back instr_valid held high -> results 10, 20; instr_ready low for 2 cycles each.
REQ-037 Reset asserted one cycle after accept (EXEC) -> no res_valid, all registers 0, instr_ready=1 after release.
